// File: rtl/imem_loader.sv
// imem_loader: UART-driven loader for the CPU instruction memory.
// Frame: HEADER, CNT_HI, CNT_LO, N words (hi byte then lo byte), CHK.
// CHK is the XOR of both count bytes and every data byte. Words are written
// from address 0 upward, one single-cycle write per word.
//
// Ports:
//   clk      - single clock
//   reset    - synchronous, active-high
//   rx_data  - received byte, qualified by rx_valid
//   rx_valid - one-cycle strobe per byte (may be back-to-back)
//   wr_en    - one-cycle instruction-memory write strobe
//   wr_addr  - write address (holds its last value between writes)
//   wr_data  - write data {hi, lo} (holds its last value between writes)
//   loading  - high while a frame is being received; stalls the CPU
//   done     - one-cycle pulse on a frame with a correct checksum
//   err      - sticky error flag, cleared by the next accepted header
module imem_loader #(
  parameter int unsigned ADDR_W         = 12,
  parameter logic [7:0]  HEADER         = 8'hA5,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [15:0]       wr_data,
  output logic              loading,
  output logic              done,
  output logic              err
);

  // One extra bit when ADDR_W=16 so the count can hold 2^ADDR_W.
  localparam int unsigned      CNT_W     = (ADDR_W >= 16) ? 17 : 16;
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] MAX_WORDS = CNT_ONE << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CNT_H,
    S_CNT_L,
    S_D_HI,
    S_D_LO,
    S_CHK
  } state_t;

  state_t            state, state_nx;
  logic [CNT_W-1:0]  count, count_nx;
  logic [CNT_W-1:0]  word_cnt, word_cnt_nx;
  logic [ADDR_W-1:0] addr, addr_nx;
  logic [7:0]        hi_byte, hi_byte_nx;
  logic [7:0]        csum, csum_nx;
  logic [31:0]       idle_cnt, idle_cnt_nx;
  logic              wr_en_nx, loading_nx, done_nx, err_nx;
  logic [ADDR_W-1:0] wr_addr_nx;
  logic [15:0]       wr_data_nx;
  logic [CNT_W-1:0]  new_count;
  logic              timeout;

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= S_IDLE;
      count    <= '0;
      word_cnt <= '0;
      addr     <= '0;
      hi_byte  <= '0;
      csum     <= '0;
      idle_cnt <= '0;
      wr_en    <= 1'b0;
      wr_addr  <= '0;
      wr_data  <= '0;
      loading  <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      word_cnt <= word_cnt_nx;
      addr     <= addr_nx;
      hi_byte  <= hi_byte_nx;
      csum     <= csum_nx;
      idle_cnt <= idle_cnt_nx;
      wr_en    <= wr_en_nx;
      wr_addr  <= wr_addr_nx;
      wr_data  <= wr_data_nx;
      loading  <= loading_nx;
      done     <= done_nx;
      err      <= err_nx;
    end
  end

  // A byte arriving on the cycle the idle count matches wins over the timeout.
  assign timeout = (TIMEOUT_CYCLES != 0) && (state != S_IDLE) && !rx_valid &&
                   (idle_cnt == TIMEOUT_CYCLES);

  assign new_count = CNT_W'({count[15:8], rx_data});

  always_comb begin
    state_nx    = state;
    count_nx    = count;
    word_cnt_nx = word_cnt;
    addr_nx     = addr;
    hi_byte_nx  = hi_byte;
    csum_nx     = csum;
    wr_en_nx    = 1'b0;
    wr_addr_nx  = wr_addr;
    wr_data_nx  = wr_data;
    loading_nx  = loading;
    done_nx     = 1'b0;
    err_nx      = err;

    // Saturating inter-byte counter, only meaningful inside a frame.
    if (rx_valid || state == S_IDLE) begin
      idle_cnt_nx = '0;
    end else if (idle_cnt != TIMEOUT_CYCLES) begin
      idle_cnt_nx = idle_cnt + 32'd1;
    end else begin
      idle_cnt_nx = idle_cnt;
    end

    if (timeout) begin
      state_nx   = S_IDLE;
      err_nx     = 1'b1;
      loading_nx = 1'b0;
    end else if (rx_valid) begin
      case (state)
        S_IDLE: begin
          if (rx_data == HEADER) begin
            state_nx    = S_CNT_H;
            loading_nx  = 1'b1;
            err_nx      = 1'b0;
            addr_nx     = '0;
            word_cnt_nx = '0;
            csum_nx     = '0;
          end
        end
        S_CNT_H: begin
          count_nx = CNT_W'({rx_data, 8'h00});
          csum_nx  = csum ^ rx_data;
          state_nx = S_CNT_L;
        end
        S_CNT_L: begin
          count_nx = new_count;
          csum_nx  = csum ^ rx_data;
          if (new_count == '0 || new_count > MAX_WORDS) begin
            err_nx     = 1'b1;
            loading_nx = 1'b0;
            state_nx   = S_IDLE;
          end else begin
            state_nx = S_D_HI;
          end
        end
        S_D_HI: begin
          hi_byte_nx = rx_data;
          csum_nx    = csum ^ rx_data;
          state_nx   = S_D_LO;
        end
        S_D_LO: begin
          wr_en_nx    = 1'b1;
          wr_addr_nx  = addr;
          wr_data_nx  = {hi_byte, rx_data};
          csum_nx     = csum ^ rx_data;
          addr_nx     = addr + ADDR_W'(1);
          word_cnt_nx = word_cnt + CNT_ONE;
          state_nx    = (word_cnt + CNT_ONE == count) ? S_CHK : S_D_HI;
        end
        S_CHK: begin
          if (rx_data == csum) begin
            done_nx = 1'b1;
          end else begin
            err_nx = 1'b1;
          end
          loading_nx = 1'b0;
          state_nx   = S_IDLE;
        end
        default: state_nx = S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
module tb_imem_loader;

  localparam int unsigned ADDR_W = 12;
  localparam int unsigned TMO    = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [7:0]        rx_data;
  logic              rx_valid;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [15:0]       wr_data;
  logic              loading;
  logic              done;
  logic              err;

  always #5 clk = ~clk;

  imem_loader #(
    .ADDR_W(ADDR_W),
    .HEADER(8'hA5),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .rx_data(rx_data),
    .rx_valid(rx_valid),
    .wr_en(wr_en),
    .wr_addr(wr_addr),
    .wr_data(wr_data),
    .loading(loading),
    .done(done),
    .err(err)
  );

  int checks   = 0;
  int failures = 0;

  // Observed traffic
  logic [27:0]  cap_q[$];
  int unsigned  cap_cyc[$];
  int unsigned  cyc = 0;
  int           done_cnt = 0;
  int           done_bad = 0;
  logic         prev_loading = 1'b0;

  // Stimulus and expectations
  logic [7:0]   frame_q[$];
  logic [27:0]  exp_q[$];
  logic         exp_done;
  logic         exp_err;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (wr_en) begin
      cap_q.push_back({wr_addr, wr_data});
      cap_cyc.push_back(cyc);
    end
    if (done) begin
      done_cnt++;
      if (!(prev_loading && !loading)) done_bad++;
    end
    prev_loading = loading;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    cap_q.delete();
    cap_cyc.delete();
    done_cnt = 0;
    done_bad = 0;
  endtask

  // Drive frame_q; each byte is followed by gap_min..gap_max idle cycles.
  task automatic send_frame(input int unsigned gap_min, input int unsigned gap_max);
    int unsigned g;
    for (int i = 0; i < frame_q.size(); i++) begin
      rx_data  = frame_q[i];
      rx_valid = 1'b1;
      tick();
      g = $urandom_range(gap_max, gap_min);
      if (g > 0) begin
        rx_valid = 1'b0;
        repeat (g) tick();
      end
    end
    rx_valid = 1'b0;
  endtask

  task automatic build_frame(input int unsigned n, input logic [7:0] chk_flip);
    logic [7:0] x;
    logic [15:0] w;
    frame_q.delete();
    frame_q.push_back(8'hA5);
    frame_q.push_back(8'(n >> 8));
    frame_q.push_back(8'(n));
    x = 8'(n >> 8) ^ 8'(n);
    for (int unsigned i = 0; i < n; i++) begin
      w = 16'($urandom);
      frame_q.push_back(w[15:8]);
      frame_q.push_back(w[7:0]);
      x ^= w[15:8] ^ w[7:0];
    end
    frame_q.push_back(x ^ chk_flip);
  endtask

  // Reference: decode the byte list directly into the expected write list
  // and end-of-frame status.
  task automatic predict();
    int unsigned n;
    logic [7:0]  x;
    exp_q.delete();
    n = 32'({frame_q[1], frame_q[2]});
    if (n == 0 || n > (1 << ADDR_W)) begin
      exp_err  = 1'b1;
      exp_done = 1'b0;
    end else begin
      x = frame_q[1] ^ frame_q[2];
      for (int unsigned i = 0; i < n; i++) begin
        exp_q.push_back({12'(i), frame_q[3+2*i], frame_q[4+2*i]});
        x ^= frame_q[3+2*i] ^ frame_q[4+2*i];
      end
      exp_done = (frame_q[3+2*n] == x);
      exp_err  = !exp_done;
    end
  endtask

  // Index of the first differing write, -1 if identical, -2 on size mismatch.
  function automatic int first_diff();
    if (cap_q.size() != exp_q.size()) return -2;
    for (int i = 0; i < exp_q.size(); i++)
      if (cap_q[i] !== exp_q[i]) return i;
    return -1;
  endfunction

  task automatic test_reset();
    reset    = 1'b1;
    rx_valid = 1'b0;
    rx_data  = 8'h00;
    tick();
    tick();
    checks++; if (wr_en !== 1'b0) begin failures++; $display("FAIL reset_wr_en got=%b exp=0", wr_en); end
    checks++; if (wr_addr !== '0) begin failures++; $display("FAIL reset_wr_addr got=%h exp=0", wr_addr); end
    checks++; if (wr_data !== '0) begin failures++; $display("FAIL reset_wr_data got=%h exp=0", wr_data); end
    checks++; if ({loading, done, err} !== 3'b000) begin failures++; $display("FAIL reset_flags got=%b exp=000", {loading, done, err}); end
    reset = 1'b0;
    tick();
  endtask

  task automatic test_basic_load();
    int d;
    clear_obs();
    frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    predict();
    send_frame(0, 3);
    repeat (3) tick();
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL basic_writes got_n=%0d exp_n=%0d diff=%0d", cap_q.size(), exp_q.size(), d); end
    checks++; if (cap_q.size() == 2 && cap_q[1] !== {12'd1, 16'hABCD}) begin failures++; $display("FAIL basic_word1 got=%h exp=%h", cap_q[1], {12'd1, 16'hABCD}); end
    checks++; if (done_cnt !== 1) begin failures++; $display("FAIL basic_done got=%0d exp=1", done_cnt); end
    checks++; if ({err, loading} !== 2'b00) begin failures++; $display("FAIL basic_err_loading got=%b exp=00", {err, loading}); end
    checks++; if (done_bad !== 0) begin failures++; $display("FAIL basic_done_align got=%0d exp=0", done_bad); end
  endtask

  task automatic test_bad_checksum();
    int d;
    clear_obs();
    frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h43};
    predict();
    send_frame(0, 3);
    repeat (3) tick();
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL badchk_writes got_n=%0d exp_n=%0d diff=%0d", cap_q.size(), exp_q.size(), d); end
    checks++; if (done_cnt !== 0) begin failures++; $display("FAIL badchk_done got=%0d exp=0", done_cnt); end
    checks++; if ({err, loading} !== 2'b10) begin failures++; $display("FAIL badchk_err_loading got=%b exp=10", {err, loading}); end
  endtask

  task automatic test_bad_count();
    logic [7:0] cnt_tab [2][2];
    cnt_tab[0][0] = 8'h00; cnt_tab[0][1] = 8'h00;
    cnt_tab[1][0] = 8'h10; cnt_tab[1][1] = 8'h01;
    for (int k = 0; k < 2; k++) begin
      clear_obs();
      frame_q = {8'hA5, cnt_tab[k][0], cnt_tab[k][1]};
      predict();
      send_frame(0, 2);
      repeat (3) tick();
      checks++; if (cap_q.size() !== 0) begin failures++; $display("FAIL badcnt%0d_writes got=%0d exp=0", k, cap_q.size()); end
      checks++; if ({err, loading, done_cnt == 0} !== {exp_err, 1'b0, 1'b1}) begin failures++; $display("FAIL badcnt%0d_flags got=%b%b done=%0d exp=%b0 done=0", k, err, loading, done_cnt, exp_err); end
    end
  endtask

  task automatic test_back_to_back();
    int d;
    clear_obs();
    frame_q = {8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h42};
    predict();
    send_frame(0, 0);
    repeat (3) tick();
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL b2b_writes got_n=%0d exp_n=%0d diff=%0d", cap_q.size(), exp_q.size(), d); end
    checks++; if (cap_cyc.size() == 2 && cap_cyc[1] - cap_cyc[0] !== 2) begin failures++; $display("FAIL b2b_spacing got=%0d exp=2", cap_cyc[1] - cap_cyc[0]); end
    checks++; if ({done_cnt == 1, err, done_bad == 0} !== 3'b101) begin failures++; $display("FAIL b2b_status done=%0d err=%b align_bad=%0d exp done=1 err=0", done_cnt, err, done_bad); end
  endtask

  task automatic test_random_frames();
    int d;
    for (int k = 0; k < 6; k++) begin
      clear_obs();
      build_frame($urandom_range(20, 1), ($urandom_range(2, 0) == 0) ? 8'(1 << $urandom_range(7, 0)) : 8'h00);
      predict();
      send_frame(0, 3);
      repeat (3) tick();
      d = first_diff();
      checks++; if (d !== -1) begin failures++; $display("FAIL rand%0d_writes got_n=%0d exp_n=%0d diff=%0d", k, cap_q.size(), exp_q.size(), d); end
      checks++; if (done_cnt !== int'(exp_done) || err !== exp_err || loading !== 1'b0) begin failures++; $display("FAIL rand%0d_status done=%0d err=%b loading=%b exp done=%0d err=%b loading=0", k, done_cnt, err, loading, exp_done, exp_err); end
    end
  endtask

  task automatic test_timeout();
    int d;
    clear_obs();
    frame_q = {8'hA5, 8'h00, 8'h01, 8'h12};
    send_frame(0, 0);
    repeat (7) tick();
    checks++; if ({err, loading} !== 2'b01) begin failures++; $display("FAIL tmo_early got=%b exp=01", {err, loading}); end
    repeat (5) tick();
    checks++; if ({err, loading} !== 2'b10) begin failures++; $display("FAIL tmo_fired got=%b exp=10", {err, loading}); end
    checks++; if (cap_q.size() !== 0) begin failures++; $display("FAIL tmo_writes got=%0d exp=0", cap_q.size()); end
    // Byte on the exact cycle the idle count matches: processed, no timeout.
    clear_obs();
    build_frame(2, 8'h00);
    predict();
    send_frame(TMO, TMO);
    repeat (3) tick();
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL tmo_edge_writes got_n=%0d exp_n=%0d diff=%0d", cap_q.size(), exp_q.size(), d); end
    checks++; if (done_cnt !== 1 || err !== 1'b0) begin failures++; $display("FAIL tmo_edge_status done=%0d err=%b exp done=1 err=0", done_cnt, err); end
  endtask

  task automatic test_reset_mid_frame();
    int d;
    clear_obs();
    frame_q = {8'hA5, 8'h00, 8'h02, 8'h12};
    send_frame(0, 0);
    rx_data  = 8'h34;
    rx_valid = 1'b1;
    reset    = 1'b1;
    tick();
    rx_valid = 1'b0;
    checks++; if ({wr_en, wr_addr, wr_data, loading, done, err} !== '0) begin failures++; $display("FAIL midrst_outputs got=%b/%h/%h/%b%b%b exp all 0", wr_en, wr_addr, wr_data, loading, done, err); end
    reset = 1'b0;
    tick();
    checks++; if (cap_q.size() !== 0) begin failures++; $display("FAIL midrst_writes got=%0d exp=0", cap_q.size()); end
    clear_obs();
    build_frame(1 << ADDR_W, 8'h00);
    predict();
    send_frame(0, 1);
    repeat (3) tick();
    d = first_diff();
    checks++; if (d !== -1) begin failures++; $display("FAIL full_writes got_n=%0d exp_n=%0d diff=%0d", cap_q.size(), exp_q.size(), d); end
    checks++; if (cap_q.size() == 4096 && cap_q[4095][27:16] !== 12'hFFF) begin failures++; $display("FAIL full_last_addr got=%h exp=fff", cap_q[4095][27:16]); end
    checks++; if (done_cnt !== 1 || err !== 1'b0 || loading !== 1'b0) begin failures++; $display("FAIL full_status done=%0d err=%b loading=%b exp done=1 err=0 loading=0", done_cnt, err, loading); end
  endtask

  initial begin
    test_reset();
    test_basic_load();
    test_bad_checksum();
    test_bad_count();
    test_back_to_back();
    test_random_frames();
    test_timeout();
    test_reset_mid_frame();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
